controle_vedacao: RTL and testbench

Sequencer for the bottle-sealing station. It drives the conveyor and the sealing actuator, and checks cork availability before each seal. It issues exactly one single-cycle `decrementar` pulse per completed seal to the cork counter, which edge-detects it, and it keeps a saturating count of sealed bottles. It sits between the operator switches and the bottle sensor on one side, and the cork counter and dispenser on the other.

---
 rtl/controle_vedacao.sv | 182 ++++++++++++++++++
 tb/tb_controle_vedacao.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_vedacao.sv
// -----------------------------------------------------------------------------
// controle_vedacao
//
// Sequencer for the bottle-sealing station. It runs the conveyor until a bottle
// sits under the sealer. It waits for the bottle to settle, then checks cork
// availability and fires the sealing actuator. Next it releases the bottle,
// and it returns to the conveyor or stops. Each completed seal produces one
// single-cycle `decrementar` pulse for the external cork counter, and bumps a
// saturating count of sealed bottles.
//
// Ports:
//   clk                50 MHz system clock
//   reset              asynchronous, active-low reset
//   start              start/restart request (rising edge only)
//   parar              stop request (level)
//   sensor_garrafa     bottle present under the sealer
//   contador_valor     current cork count (0-99)
//   dispensador_ativo  cork dispenser refilling
//   motor_esteira      conveyor motor on
//   atuador_vedacao    sealing actuator on
//   decrementar        one-cycle pulse per completed seal
//   falta_rolha        waiting because the cork count is zero
//   erro_esteira       conveyor timeout flag
//   estado_atual       current state encoding
//   garrafas_vedadas   sealed bottle count, saturating at MAX_GARRAFAS
// -----------------------------------------------------------------------------
module controle_vedacao #(
    parameter logic [25:0] TEMPO_ESTABILIZA = 26'd500000,
    parameter logic [25:0] TEMPO_VEDACAO    = 26'd25000000,
    parameter logic [25:0] TIMEOUT_ESTEIRA  = 26'd50000000,
    parameter logic [6:0]  MAX_GARRAFAS     = 7'd99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       parar,
    input  logic       sensor_garrafa,
    input  logic [6:0] contador_valor,
    input  logic       dispensador_ativo,
    output logic       motor_esteira,
    output logic       atuador_vedacao,
    output logic       decrementar,
    output logic       falta_rolha,
    output logic       erro_esteira,
    output logic [2:0] estado_atual,
    output logic [6:0] garrafas_vedadas
);

    localparam logic [2:0] PARADO     = 3'd0;
    localparam logic [2:0] ESTEIRA    = 3'd1;
    localparam logic [2:0] ESTABILIZA = 3'd2;
    localparam logic [2:0] VEDANDO    = 3'd3;
    localparam logic [2:0] LIBERANDO  = 3'd4;
    localparam logic [2:0] SEM_ROLHA  = 3'd5;
    localparam logic [2:0] ERRO       = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [25:0] timer_q, timer_d;
    logic        pedido_parada_q, pedido_parada_d;
    logic        start_prev_q;
    logic [6:0]  garrafas_q, garrafas_d;
    logic        motor_q, motor_d;
    logic        atuador_q, atuador_d;
    logic        decrementar_q, decrementar_d;
    logic        falta_q, falta_d;
    logic        erro_q, erro_d;

    logic        start_rise;
    logic        conta_timer;
    logic        fim_vedacao;
    logic        sem_rolha_cond;

    assign start_rise     = start & ~start_prev_q;
    assign sem_rolha_cond = (contador_valor == 7'd0) | dispensador_ativo;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d         = state_q;
        pedido_parada_d = pedido_parada_q;

        case (state_q)
            PARADO: begin
                if (start_rise && !parar) begin
                    state_d         = ESTEIRA;
                    pedido_parada_d = 1'b0;
                end
            end
            ESTEIRA: begin
                if (parar)                                   state_d = PARADO;
                else if (sensor_garrafa)                     state_d = ESTABILIZA;
                else if (timer_q == TIMEOUT_ESTEIRA - 26'd1) state_d = ERRO;
            end
            ESTABILIZA: begin
                if (parar)                 state_d = PARADO;
                else if (!sensor_garrafa)  state_d = ESTEIRA;
                else if (timer_q == TEMPO_ESTABILIZA - 26'd1)
                    state_d = sem_rolha_cond ? SEM_ROLHA : VEDANDO;
            end
            SEM_ROLHA: begin
                if (parar)                state_d = PARADO;
                else if (!sem_rolha_cond) state_d = VEDANDO;
            end
            VEDANDO: begin
                // A stop request is remembered; the seal always completes.
                if (parar) pedido_parada_d = 1'b1;
                if (timer_q == TEMPO_VEDACAO - 26'd1) state_d = LIBERANDO;
            end
            LIBERANDO: begin
                if (parar) pedido_parada_d = 1'b1;
                if (!sensor_garrafa)
                    state_d = pedido_parada_q ? PARADO : ESTEIRA;
                else if (timer_q == TIMEOUT_ESTEIRA - 26'd1)
                    state_d = ERRO;
            end
            ERRO: begin
                if (parar) state_d = PARADO;
                else if (start_rise) begin
                    state_d         = ESTEIRA;
                    pedido_parada_d = 1'b0;
                end
            end
            default: state_d = PARADO;   // illegal encoding 7 recovers
        endcase

        // The timer restarts at zero on every state change and only runs in
        // the states that have a time limit.
        conta_timer = (state_d == state_q) &&
                      ((state_q == ESTEIRA) || (state_q == ESTABILIZA) ||
                       (state_q == VEDANDO) || (state_q == LIBERANDO));
        timer_d = conta_timer ? timer_q + 26'd1 : 26'd0;

        fim_vedacao   = (state_q == VEDANDO) && (state_d == LIBERANDO);
        decrementar_d = fim_vedacao;
        garrafas_d    = (fim_vedacao && (garrafas_q != MAX_GARRAFAS))
                        ? garrafas_q + 7'd1 : garrafas_q;

        // Outputs are decoded from the next state so the registered value
        // lines up with estado_atual in the same cycle.
        motor_d   = (state_d == ESTEIRA) || (state_d == LIBERANDO);
        atuador_d = (state_d == VEDANDO);
        falta_d   = (state_d == SEM_ROLHA) && (contador_valor == 7'd0);
        erro_d    = (state_d == ERRO);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= PARADO;
            timer_q         <= 26'd0;
            pedido_parada_q <= 1'b0;
            start_prev_q    <= 1'b0;
            garrafas_q      <= 7'd0;
            motor_q         <= 1'b0;
            atuador_q       <= 1'b0;
            decrementar_q   <= 1'b0;
            falta_q         <= 1'b0;
            erro_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            pedido_parada_q <= pedido_parada_d;
            start_prev_q    <= start;
            garrafas_q      <= garrafas_d;
            motor_q         <= motor_d;
            atuador_q       <= atuador_d;
            decrementar_q   <= decrementar_d;
            falta_q         <= falta_d;
            erro_q          <= erro_d;
        end
    end

    assign motor_esteira    = motor_q;
    assign atuador_vedacao  = atuador_q;
    assign decrementar      = decrementar_q;
    assign falta_rolha      = falta_q;
    assign erro_esteira     = erro_q;
    assign estado_atual     = state_q;
    assign garrafas_vedadas = garrafas_q;

endmodule

// File: tb/tb_controle_vedacao.sv
// -----------------------------------------------------------------------------
// tb_controle_vedacao
//
// Directed scenarios with randomized delays and cork values. Expected state
// timelines come from the station's timing rules: settle time, seal time,
// conveyor timeout. A small scoreboard tracks seals and the saturating bottle
// count, and a monitor measures decrementar pulses and actuator on-time.
// -----------------------------------------------------------------------------
module tb_controle_vedacao;

    localparam int TE  = 4;
    localparam int TV  = 8;
    localparam int TO  = 50;
    localparam int MAX = 99;

    localparam int ST_PARADO     = 0;
    localparam int ST_ESTEIRA    = 1;
    localparam int ST_ESTABILIZA = 2;
    localparam int ST_VEDANDO    = 3;
    localparam int ST_LIBERANDO  = 4;
    localparam int ST_SEM_ROLHA  = 5;
    localparam int ST_ERRO       = 6;

    logic       clk;
    logic       reset;
    logic       start;
    logic       parar;
    logic       sensor_garrafa;
    logic [6:0] contador_valor;
    logic       dispensador_ativo;
    logic       motor_esteira;
    logic       atuador_vedacao;
    logic       decrementar;
    logic       falta_rolha;
    logic       erro_esteira;
    logic [2:0] estado_atual;
    logic [6:0] garrafas_vedadas;

    int checks   = 0;
    int failures = 0;

    int exp_seals    = 0;
    int exp_garrafas = 0;

    int dec_pulses   = 0;
    int dec_run      = 0;
    int dec_max_run  = 0;
    int act_run      = 0;
    int last_act_len = 0;

    controle_vedacao #(
        .TEMPO_ESTABILIZA (26'd4),
        .TEMPO_VEDACAO    (26'd8),
        .TIMEOUT_ESTEIRA  (26'd50),
        .MAX_GARRAFAS     (7'd99)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .parar             (parar),
        .sensor_garrafa    (sensor_garrafa),
        .contador_valor    (contador_valor),
        .dispensador_ativo (dispensador_ativo),
        .motor_esteira     (motor_esteira),
        .atuador_vedacao   (atuador_vedacao),
        .decrementar       (decrementar),
        .falta_rolha       (falta_rolha),
        .erro_esteira      (erro_esteira),
        .estado_atual      (estado_atual),
        .garrafas_vedadas  (garrafas_vedadas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse and on-time monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (decrementar) begin
            dec_run <= dec_run + 1;
            if (dec_run == 0) dec_pulses <= dec_pulses + 1;
            if (dec_run + 1 > dec_max_run) dec_max_run <= dec_run + 1;
        end else begin
            dec_run <= 0;
        end
        if (atuador_vedacao) begin
            act_run <= act_run + 1;
        end else begin
            if (act_run != 0) last_act_len <= act_run;
            act_run <= 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_state(input string tag, input int exp);
        check({tag, "_state"}, 32'(estado_atual), 32'(exp));
    endtask

    task automatic check_io(input string tag, input logic m, input logic a,
                            input logic d, input logic f, input logic e);
        check({tag, "_motor"},   32'(motor_esteira),   32'(m));
        check({tag, "_atuador"}, 32'(atuador_vedacao), 32'(a));
        check({tag, "_decr"},    32'(decrementar),     32'(d));
        check({tag, "_falta"},   32'(falta_rolha),     32'(f));
        check({tag, "_erro"},    32'(erro_esteira),    32'(e));
    endtask

    task automatic start_pulse(input string tag, input int exp_state);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check_state(tag, exp_state);
    endtask

    // From ESTEIRA: idle `extra` cycles, present a bottle, hold it through the
    // whole settle window and stop on the decision edge.
    task automatic stabilise(input string tag, input int extra);
        tick(extra);
        check_state({tag, "_esteira"}, ST_ESTEIRA);
        sensor_garrafa = 1'b1;
        tick(1);
        check_state({tag, "_estab_in"}, ST_ESTABILIZA);
        check({tag, "_estab_motor"}, 32'(motor_esteira), 32'd0);
        tick(TE - 1);
        check_state({tag, "_estab_last"}, ST_ESTABILIZA);
        tick(1);
    endtask

    // Finish a seal that has already spent `spent` edges in VEDANDO, release
    // the bottle and confirm the state reached afterwards.
    task automatic finish_seal(input string tag, input int spent, input int after_state);
        int hold;
        tick(TV - 1 - spent);
        check_state({tag, "_ved_last"}, ST_VEDANDO);
        check({tag, "_ved_act"}, 32'(atuador_vedacao), 32'd1);
        tick(1);
        exp_seals++;
        if (exp_garrafas < MAX) exp_garrafas++;
        check_state({tag, "_lib_in"}, ST_LIBERANDO);
        check_io({tag, "_lib_in"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check({tag, "_garrafas"}, 32'(garrafas_vedadas), 32'(exp_garrafas));
        hold = $urandom_range(1, 3);
        tick(hold);
        check_state({tag, "_lib_hold"}, ST_LIBERANDO);
        check_io({tag, "_lib_hold"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check({tag, "_act_len"}, 32'(last_act_len), 32'(TV));
        check({tag, "_pulses"}, 32'(dec_pulses), 32'(exp_seals));
        sensor_garrafa = 1'b0;
        tick(1);
        check_state({tag, "_after"}, after_state);
        check({tag, "_after_motor"}, 32'(motor_esteira),
              (after_state == ST_ESTEIRA) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int g;
        int w;

        reset             = 1'b0;
        start             = 1'b0;
        parar             = 1'b0;
        sensor_garrafa    = 1'b0;
        contador_valor    = 7'd20;
        dispensador_ativo = 1'b0;

        // Reset state
        tick(3);
        check_state("rst", ST_PARADO);
        check_io("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_garrafas", 32'(garrafas_vedadas), 32'd0);
        reset = 1'b1;
        tick(2);
        check_state("idle", ST_PARADO);

        // Normal cycle
        start_pulse("norm_start", ST_ESTEIRA);
        check_io("norm_esteira", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stabilise("norm", 4);
        check_state("norm_ved", ST_VEDANDO);
        check_io("norm_ved", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_seal("norm", 0, ST_ESTEIRA);
        check("norm_pulse_width", 32'(dec_max_run), 32'd1);

        // Sensor glitch shorter than the settle window
        g = $urandom_range(1, TE - 1);
        sensor_garrafa = 1'b1;
        tick(1);
        check_state("glitch_in", ST_ESTABILIZA);
        tick(g - 1);
        check_state("glitch_hold", ST_ESTABILIZA);
        sensor_garrafa = 1'b0;
        tick(1);
        check_state("glitch_back", ST_ESTEIRA);
        check("glitch_act", 32'(atuador_vedacao), 32'd0);
        check("glitch_pulses", 32'(dec_pulses), 32'(exp_seals));

        // No corks
        contador_valor = 7'd0;
        stabilise("nocork", $urandom_range(0, 10));
        check_state("nocork", ST_SEM_ROLHA);
        check_io("nocork", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        w = $urandom_range(1, 6);
        tick(w);
        check_state("nocork_wait", ST_SEM_ROLHA);
        check("nocork_wait_falta", 32'(falta_rolha), 32'd1);
        contador_valor = 7'd15;
        tick(1);
        check_state("nocork_ved", ST_VEDANDO);
        check_io("nocork_ved", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_seal("nocork", 0, ST_ESTEIRA);

        // Dispenser busy
        contador_valor    = 7'd5;
        dispensador_ativo = 1'b1;
        stabilise("disp", $urandom_range(0, 10));
        check_state("disp", ST_SEM_ROLHA);
        check_io("disp", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick($urandom_range(1, 6));
        check_state("disp_wait", ST_SEM_ROLHA);
        dispensador_ativo = 1'b0;
        tick(1);
        check_state("disp_ved", ST_VEDANDO);
        finish_seal("disp", 0, ST_ESTEIRA);

        // Stop during seal: seal and release complete, then PARADO
        contador_valor = 7'($urandom_range(1, 99));
        stabilise("stop", $urandom_range(0, 10));
        check_state("stop_ved", ST_VEDANDO);
        tick(1);
        parar = 1'b1;
        tick(2);
        parar = 1'b0;
        finish_seal("stop", 3, ST_PARADO);
        check_io("stop_parado", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(3);
        check_state("stop_stays", ST_PARADO);

        // Conveyor timeout after restart
        start_pulse("to_start", ST_ESTEIRA);
        tick(TO - 1);
        check_state("to_last", ST_ESTEIRA);
        tick(1);
        check_state("to_erro", ST_ERRO);
        check_io("to_erro", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(2);
        check_state("to_erro_hold", ST_ERRO);
        start_pulse("to_restart", ST_ESTEIRA);
        check_io("to_restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Stop wins over start; start needs a fresh rising edge
        parar = 1'b1;
        tick(1);
        check_state("pp_stop", ST_PARADO);
        start = 1'b1;
        tick(1);
        check_state("pp_both", ST_PARADO);
        parar = 1'b0;
        tick(1);
        check_state("pp_level", ST_PARADO);
        start = 1'b0;
        tick(1);
        start_pulse("pp_restart", ST_ESTEIRA);
        check("pp_garrafas_kept", 32'(garrafas_vedadas), 32'(exp_garrafas));

        // Saturation: 100 further seals
        for (int i = 0; i < 100; i++) begin
            contador_valor = 7'($urandom_range(1, 99));
            stabilise("sat", $urandom_range(0, 3));
            check_state("sat_ved", ST_VEDANDO);
            finish_seal("sat", 0, ST_ESTEIRA);
        end
        check("sat_final", 32'(garrafas_vedadas), 32'(MAX));
        check("sat_pulse_width", 32'(dec_max_run), 32'd1);

        // Reset mid-VEDANDO
        stabilise("rstv", 2);
        check_state("rstv_ved", ST_VEDANDO);
        tick(3);
        check("rstv_act_before", 32'(atuador_vedacao), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_state("rstv_async", ST_PARADO);
        check_io("rstv_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rstv_garrafas", 32'(garrafas_vedadas), 32'd0);
        tick(2);
        reset = 1'b1;
        tick(2);
        check_state("rstv_after", ST_PARADO);
        check("rstv_no_pulse", 32'(dec_pulses), 32'(exp_seals));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
